// File: rtl/can_error_scheduler_pkg.sv
// rtl/can_error_scheduler_pkg.sv - shared types and fault-confinement constants for the CAN error scheduler
package can_error_scheduler_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT} sched_state_t;
   typedef enum logic [1:0] {ACTIVE, PASSIVE, BUSOFF} err_state_t;

   localparam logic [9:0] TEC_INC     = 10'd8;
   localparam logic [8:0] PASSIVE_LIM = 9'd127;
   localparam logic [8:0] BUSOFF_LIM  = 9'd256;
   localparam logic [7:0] REC_RESTORE = 8'd119;
   localparam logic [3:0] RECOV_BITS  = 4'd11;
   localparam logic [7:0] RECOV_RUNS  = 8'd128;

endpackage

// File: rtl/can_error_scheduler_if.sv
// rtl/can_error_scheduler_if.sv - checker/generator-side signal bundle of the CAN error scheduler
interface can_error_scheduler_if;
   import can_error_scheduler_pkg::*;

   logic       err_bit, err_stuff, err_crc, err_form, err_ack;
   logic       tx_mode, tx_ok, rx_ok, ovrld_req, gen_done_n, RX;
   logic       start_n, passive_flag, busy, gen_timeout;
   err_state_t err_state;
   logic [8:0] tec;
   logic [7:0] rec;

   modport master (
      output err_bit, err_stuff, err_crc, err_form, err_ack,
      output tx_mode, tx_ok, rx_ok, ovrld_req, gen_done_n, RX,
      input  start_n, passive_flag, busy, gen_timeout, err_state, tec, rec
   );

   modport slave (
      input  err_bit, err_stuff, err_crc, err_form, err_ack,
      input  tx_mode, tx_ok, rx_ok, ovrld_req, gen_done_n, RX,
      output start_n, passive_flag, busy, gen_timeout, err_state, tec, rec
   );

endinterface

// File: rtl/can_error_scheduler_fault_counters.sv
// rtl/can_error_scheduler_fault_counters.sv - TEC/REC fault confinement with bus-off recovery
module can_fault_counters
   import can_error_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       err_evt,
   input  logic       tx_mode,
   input  logic       tx_ok,
   input  logic       rx_ok,
   input  logic       rx,
   output logic [8:0] tec,
   output logic [7:0] rec,
   output err_state_t err_state
);

   logic [8:0] tec_nxt;
   logic [7:0] rec_nxt;
   logic [9:0] tec_sum;
   logic [3:0] bit_cnt, bit_nxt;
   logic [7:0] run_cnt, run_nxt;
   err_state_t state_nxt;

   always_comb begin
      tec_sum = {1'b0, tec} + TEC_INC;
      tec_nxt = tec;
      rec_nxt = rec;
      bit_nxt = bit_cnt;
      run_nxt = run_cnt;
      if (err_state == BUSOFF) begin
         // counters frozen; only recessive runs on the bus move us towards recovery
         if (!rx) begin
            bit_nxt = '0;
         end else if (bit_cnt + 4'd1 == RECOV_BITS) begin
            bit_nxt = '0;
            if (run_cnt + 8'd1 == RECOV_RUNS) begin
               run_nxt = '0;
               tec_nxt = '0;
               rec_nxt = '0;
            end else begin
               run_nxt = run_cnt + 8'd1;
            end
         end else begin
            bit_nxt = bit_cnt + 4'd1;
         end
      end else begin
         bit_nxt = '0;
         run_nxt = '0;
         if (err_evt) begin
            if (tx_mode)
               tec_nxt = (tec_sum > {1'b0, BUSOFF_LIM}) ? BUSOFF_LIM : tec_sum[8:0];
            else if (rec != 8'hff)
               rec_nxt = rec + 8'd1;
         end else begin
            if (tx_ok && tec != '0)
               tec_nxt = tec - 9'd1;
            if (rx_ok) begin
               if (rec > PASSIVE_LIM[7:0])
                  rec_nxt = REC_RESTORE;
               else if (rec != '0)
                  rec_nxt = rec - 8'd1;
            end
         end
      end
      if (tec_nxt >= BUSOFF_LIM)
         state_nxt = BUSOFF;
      else if (tec_nxt > PASSIVE_LIM || rec_nxt > PASSIVE_LIM[7:0])
         state_nxt = PASSIVE;
      else
         state_nxt = ACTIVE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tec       <= '0;
         rec       <= '0;
         bit_cnt   <= '0;
         run_cnt   <= '0;
         err_state <= ACTIVE;
      end else begin
         tec       <= tec_nxt;
         rec       <= rec_nxt;
         bit_cnt   <= bit_nxt;
         run_cnt   <= run_nxt;
         err_state <= state_nxt;
      end
   end

endmodule

// File: rtl/can_error_scheduler.sv
// rtl/can_error_scheduler.sv - arbitrates error/overload requests onto the flag generator start strobe
module can_error_scheduler
   import can_error_scheduler_pkg::*;
#(
   parameter int TIMEOUT_BITS = 63,
   parameter int MAX_OVRLD    = 2
) (
   input  logic SP,
   input  logic reset,
   can_error_scheduler_if.slave bus
);

   localparam logic [6:0] TIMER_LAST = 7'(TIMEOUT_BITS - 1);
   localparam logic [3:0] OVRLD_LIM  = 4'(MAX_OVRLD);

   sched_state_t state, state_nxt;
   err_state_t   err_state;
   logic [8:0]   tec;
   logic [7:0]   rec;
   logic [6:0]   timer;
   logic [3:0]   ovrld_cnt, cnt_base;
   logic         err_evt, busoff, err_req, ok_clr, start_err, start_ovl, timed_out;
   logic         pending, passive_q, timeout_q;

   can_fault_counters u_counters (
      .clk       (SP),
      .reset     (reset),
      .err_evt   (err_evt),
      .tx_mode   (bus.tx_mode),
      .tx_ok     (bus.tx_ok),
      .rx_ok     (bus.rx_ok),
      .rx        (bus.RX),
      .tec       (tec),
      .rec       (rec),
      .err_state (err_state)
   );

   always_comb begin
      err_evt   = |{bus.err_bit, bus.err_stuff, bus.err_crc, bus.err_form, bus.err_ack};
      busoff    = (err_state == BUSOFF);
      err_req   = err_evt && !busoff;
      ok_clr    = !busoff && (err_evt || bus.tx_ok || bus.rx_ok);
      cnt_base  = ok_clr ? '0 : ovrld_cnt;
      // an error in the same IDLE cycle always pre-empts overload
      start_err = (state == IDLE) && err_req;
      start_ovl = (state == IDLE) && !err_req && !busoff &&
                  (bus.ovrld_req || pending) && (cnt_base < OVRLD_LIM);
      timed_out = (state == WAIT) && bus.gen_done_n && (timer == TIMER_LAST);
   end

   always_ff @(posedge SP or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_err || start_ovl) state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (!bus.gen_done_n || timed_out) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.start_n = (state != START);
      bus.busy    = (state != IDLE);
   end

   always_ff @(posedge SP or posedge reset) begin
      if (reset) begin
         passive_q <= 1'b0;
         ovrld_cnt <= '0;
         pending   <= 1'b0;
         timer     <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (start_err) begin
            passive_q <= (err_state == PASSIVE);
            ovrld_cnt <= '0;
         end else if (start_ovl) begin
            ovrld_cnt <= cnt_base + 4'd1;
         end else begin
            ovrld_cnt <= cnt_base;
         end
         if (state == IDLE)
            pending <= 1'b0;
         else if (bus.ovrld_req && !busoff)
            pending <= 1'b1;
         if (state == START)
            timer <= '0;
         else if (state == WAIT)
            timer <= timer + 7'd1;
         if (timed_out)
            timeout_q <= 1'b1;
      end
   end

   assign bus.passive_flag = passive_q;
   assign bus.gen_timeout  = timeout_q;
   assign bus.err_state    = err_state;
   assign bus.tec          = tec;
   assign bus.rec          = rec;

endmodule

// File: tb/tb_can_error_scheduler.sv
// tb/tb_can_error_scheduler.sv - self-checking bench for can_error_scheduler against a behavioural model
module tb_can_error_scheduler;
   import can_error_scheduler_pkg::*;

   logic SP = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   // behavioural model of the observable behaviour
   int m_tec, m_rec, m_state, m_bits, m_runs;
   int m_phase, m_waited, m_ocnt, m_pend, m_pflag, m_tmo;

   can_error_scheduler_if bus ();

   can_error_scheduler #(.TIMEOUT_BITS(63), .MAX_OVRLD(2)) dut (
      .SP    (SP),
      .reset (reset),
      .bus   (bus)
   );

   always #5 SP = ~SP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tec = 0; m_rec = 0; m_state = 0; m_bits = 0; m_runs = 0;
      m_phase = 0; m_waited = 0; m_ocnt = 0; m_pend = 0; m_pflag = 0; m_tmo = 0;
   endtask

   task automatic model_step();
      int e, bo, clr, st0, base;
      e   = int'(bus.err_bit | bus.err_stuff | bus.err_crc | bus.err_form | bus.err_ack);
      st0 = m_state;
      bo  = (st0 == 2);
      if (bo) begin
         if (bus.RX == 1'b0) m_bits = 0;
         else begin
            m_bits++;
            if (m_bits == 11) begin
               m_bits = 0;
               m_runs++;
               if (m_runs == 128) begin m_runs = 0; m_tec = 0; m_rec = 0; end
            end
         end
      end else begin
         m_bits = 0; m_runs = 0;
         if (e != 0) begin
            if (bus.tx_mode) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
            else             m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
         end else begin
            if (bus.tx_ok && m_tec > 0) m_tec--;
            if (bus.rx_ok) m_rec = (m_rec > 127) ? 119 : ((m_rec > 0) ? m_rec - 1 : 0);
         end
      end
      m_state = (m_tec >= 256) ? 2 : ((m_tec > 127 || m_rec > 127) ? 1 : 0);
      clr = (!bo && (e != 0 || bus.tx_ok || bus.rx_ok)) ? 1 : 0;
      case (m_phase)
         0: begin
            if (e != 0 && !bo) begin
               m_phase = 1; m_pflag = (st0 == 1); m_ocnt = 0;
            end else begin
               base = clr ? 0 : m_ocnt;
               if (!bo && (bus.ovrld_req || m_pend != 0) && base < 2) begin
                  m_phase = 1; m_ocnt = base + 1;
               end else m_ocnt = base;
            end
            m_pend = 0;
         end
         1: begin
            m_phase = 2; m_waited = 0;
            if (clr) m_ocnt = 0;
            if (!bo && bus.ovrld_req) m_pend = 1;
         end
         default: begin
            m_waited++;
            if (clr) m_ocnt = 0;
            if (!bo && bus.ovrld_req) m_pend = 1;
            if (!bus.gen_done_n) m_phase = 0;
            else if (m_waited == 63) begin m_phase = 0; m_tmo = 1; end
         end
      endcase
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".start_n"},      32'(bus.start_n),      32'(m_phase != 1));
      chk({tag, ".busy"},         32'(bus.busy),         32'(m_phase != 0));
      chk({tag, ".passive_flag"}, 32'(bus.passive_flag), 32'(m_pflag));
      chk({tag, ".err_state"},    32'(bus.err_state),    32'(m_state));
      chk({tag, ".tec"},          32'(bus.tec),          32'(m_tec));
      chk({tag, ".rec"},          32'(bus.rec),          32'(m_rec));
      chk({tag, ".gen_timeout"},  32'(bus.gen_timeout),  32'(m_tmo));
   endtask

   task automatic clear_pulses();
      bus.err_bit = 0; bus.err_stuff = 0; bus.err_crc = 0; bus.err_form = 0; bus.err_ack = 0;
      bus.tx_ok = 0; bus.rx_ok = 0; bus.ovrld_req = 0; bus.gen_done_n = 1;
   endtask

   task automatic cyc(input string tag);
      @(posedge SP);
      model_step();
      #1;
      check_all(tag);
      clear_pulses();
   endtask

   task automatic do_reset(input string tag);
      @(negedge SP);
      reset = 1;
      #1;
      model_reset();
      check_all(tag);
      chk({tag, ".start_n_rst"}, 32'(bus.start_n), 32'd1);
      chk({tag, ".busy_rst"},    32'(bus.busy),    32'd0);
      @(negedge SP);
      reset = 0;
   endtask

   task automatic ack_frame(input string tag);
      cyc({tag, ".wait"});
      bus.gen_done_n = 0;
      cyc({tag, ".done"});
   endtask

   initial begin
      bus.tx_mode = 0; bus.RX = 1; reset = 1;
      clear_pulses();
      model_reset();
      do_reset("reset");

      // receiver error
      bus.err_crc = 1; bus.tx_mode = 0;
      cyc("rx_err");
      chk("rx_err.rec1", 32'(bus.rec), 32'd1);
      chk("rx_err.start_low", 32'(bus.start_n), 32'd0);
      chk("rx_err.active_flag", 32'(bus.passive_flag), 32'd0);
      ack_frame("rx_err");
      chk("rx_err.busy_clear", 32'(bus.busy), 32'd0);

      // transmitter errors to error-passive
      for (int i = 0; i < 16; i++) begin
         bus.err_bit = 1; bus.tx_mode = 1;
         cyc("tx_err");
         ack_frame("tx_err");
      end
      chk("tx_err.tec128", 32'(bus.tec), 32'd128);
      chk("tx_err.passive", 32'(bus.err_state), 32'(PASSIVE));
      bus.err_bit = 1;
      cyc("tx_err17");
      chk("tx_err17.passive_flag", 32'(bus.passive_flag), 32'd1);
      ack_frame("tx_err17");

      // bus-off entry, errors ignored, recovery with one broken run
      bus.RX = 0;
      for (int g = 0; g < 40 && m_state != 2; g++) begin
         bus.err_stuff = 1; bus.tx_mode = 1;
         cyc("to_busoff");
         ack_frame("to_busoff");
      end
      chk("busoff.state", 32'(bus.err_state), 32'(BUSOFF));
      bus.err_bit = 1;
      cyc("busoff.ignored");
      chk("busoff.no_start", 32'(bus.start_n), 32'd1);
      chk("busoff.tec_frozen", 32'(bus.tec), 32'd256);
      for (int r = 0; r < 128; r++) begin
         for (int b = 0; b < 11; b++) begin
            if (r == 64 && b == 5) begin
               bus.RX = 0;
               cyc("recov.dominant");
            end
            bus.RX = 1;
            cyc("recov");
         end
      end
      chk("recov.still_busoff", 32'(bus.err_state), 32'(BUSOFF));
      for (int k = 0; k < 5; k++) cyc("recov.tail");
      chk("recov.active", 32'(bus.err_state), 32'(ACTIVE));
      chk("recov.tec0", 32'(bus.tec), 32'd0);
      chk("recov.rec0", 32'(bus.rec), 32'd0);

      // overload limit
      bus.tx_mode = 0;
      for (int i = 0; i < 3; i++) begin
         bus.ovrld_req = 1;
         cyc("ovrld");
         chk("ovrld.start_n", 32'(bus.start_n), (i < 2) ? 32'd0 : 32'd1);
         if (i < 2) ack_frame("ovrld");
      end
      bus.rx_ok = 1;
      cyc("ovrld.rx_ok");
      bus.ovrld_req = 1;
      cyc("ovrld.after_ok");
      chk("ovrld.after_ok_start", 32'(bus.start_n), 32'd0);
      ack_frame("ovrld.after_ok");

      // simultaneous error + overload + rx_ok with rec=5
      for (int i = 0; i < 5; i++) begin
         bus.err_ack = 1;
         cyc("rec_up");
         ack_frame("rec_up");
      end
      bus.err_form = 1; bus.ovrld_req = 1; bus.rx_ok = 1;
      cyc("simul");
      chk("simul.rec6", 32'(bus.rec), 32'd6);
      chk("simul.start", 32'(bus.start_n), 32'd0);
      ack_frame("simul");
      for (int i = 0; i < 3; i++) begin
         cyc("simul.idle");
         chk("simul.no_ovrld", 32'(bus.start_n), 32'd1);
      end

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bus.err_bit    = ($urandom_range(0, 15) == 0);
         bus.err_crc    = ($urandom_range(0, 31) == 0);
         bus.tx_mode    = $urandom_range(0, 1) != 0;
         bus.tx_ok      = ($urandom_range(0, 7) == 0);
         bus.rx_ok      = ($urandom_range(0, 7) == 0);
         bus.ovrld_req  = ($urandom_range(0, 9) == 0);
         bus.gen_done_n = ($urandom_range(0, 3) != 0);
         bus.RX         = ($urandom_range(0, 15) != 0);
         cyc("rand");
      end
      bus.RX = 1;
      do_reset("reset2");

      // generator hang, then reset mid-WAIT
      bus.err_ack = 1; bus.tx_mode = 0;
      cyc("hang.start");
      for (int i = 0; i < 70; i++) cyc("hang");
      chk("hang.timeout", 32'(bus.gen_timeout), 32'd1);
      chk("hang.idle", 32'(bus.busy), 32'd0);
      bus.err_bit = 1;
      cyc("hang.again");
      cyc("hang.again_wait");
      chk("hang.sticky", 32'(bus.gen_timeout), 32'd1);
      cyc("hang.mid_wait");
      do_reset("reset_mid_wait");
      chk("reset_mid_wait.timeout", 32'(bus.gen_timeout), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
